led_bar_pwm_driver: RTL and testbench

//  Downstream consumer of the 8-bit LED PIO output byte. Treats the byte as a bar-graph level
//  0..255 and drives 8 LEDs:
//  - level[7:5] LEDs fully on.
//  - The next LED is PWM-dimmed with duty level[4:0]/32.
//  - The displayed level fades toward each new target at a programmable rate.

---
 rtl/led_pwm_pkg.sv | 29 ++
 rtl/led_bar_pwm_driver_if.sv | 16 +
 rtl/led_pwm_timebase.sv | 38 +++
 rtl/led_bar_pwm_driver.sv | 102 ++++++++++
 tb/tb_led_bar_pwm_driver.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/led_pwm_pkg.sv
// Shared widths, the fade FSM state type and the bar-graph decode for the LED PWM driver.
package led_pwm_pkg;

    localparam int LEVEL_W   = 8;
    localparam int NUM_LEDS  = 8;
    localparam int FRAC_W    = 5;
    localparam int PWM_STEPS = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } fade_state_e;

    // Upper bits pick how many LEDs are solid; the lower bits set the duty of the next one.
    function automatic logic [NUM_LEDS-1:0] led_decode(input logic [LEVEL_W-1:0] level,
                                                      input logic [FRAC_W-1:0]  pwm_cnt);
        logic [LEVEL_W-FRAC_W-1:0] lit;
        logic [FRAC_W-1:0]         frac;
        logic [NUM_LEDS-1:0]       leds;
        lit  = level[LEVEL_W-1:FRAC_W];
        frac = level[FRAC_W-1:0];
        for (int i = 0; i < NUM_LEDS; i++) begin
            leds[i] = (i < int'(lit)) || ((i == int'(lit)) && (pwm_cnt < frac));
        end
        return leds;
    endfunction

endpackage

// File: rtl/led_bar_pwm_driver_if.sv
// Bundle between the PIO output byte and the LED pins, plus fade FSM debug visibility.
interface led_bar_pwm_driver_if;
    import led_pwm_pkg::*;

    // level_in is a level, not a transaction: there is no valid/ready, it is sampled every cycle.
    logic [LEVEL_W-1:0]  level_in;
    logic [NUM_LEDS-1:0] led_out;
    logic                pwm_sync;
    logic                busy;
    fade_state_e         fade_state;
    logic [LEVEL_W-1:0]  cur_level;

    modport master (output level_in, input led_out, pwm_sync, busy, fade_state, cur_level);
    modport slave  (input level_in, output led_out, pwm_sync, busy, fade_state, cur_level);

endinterface

// File: rtl/led_pwm_timebase.sv
// Prescaler and 5-bit PWM counter; boundary marks the last tick of each PWM period.
module led_pwm_timebase
    import led_pwm_pkg::*;
#(
    parameter int CLK_DIV = 50
) (
    input  logic              clk,
    input  logic              reset,
    output logic              tick_o,
    output logic [FRAC_W-1:0] pwm_cnt_o,
    output logic              boundary_o
);

    localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PRE_W-1:0]  prescaler_q, prescaler_d;
    logic [FRAC_W-1:0] pwm_cnt_q, pwm_cnt_d;

    assign tick_o     = (prescaler_q == PRE_W'(CLK_DIV - 1));
    assign boundary_o = tick_o && (pwm_cnt_q == FRAC_W'(PWM_STEPS - 1));
    assign pwm_cnt_o  = pwm_cnt_q;

    always_comb begin
        prescaler_d = tick_o ? '0 : prescaler_q + 1'b1;
        pwm_cnt_d   = tick_o ? pwm_cnt_q + 1'b1 : pwm_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler_q <= '0;
            pwm_cnt_q   <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            pwm_cnt_q   <= pwm_cnt_d;
        end
    end

endmodule

// File: rtl/led_bar_pwm_driver.sv
// Bar-graph LED driver: fades the displayed level toward the PIO byte and PWM-dims the edge LED.
module led_bar_pwm_driver
    import led_pwm_pkg::*;
#(
    parameter int CLK_DIV      = 50,
    parameter int FADE_PERIODS = 4
) (
    input logic                 clk,
    input logic                 reset,
    led_bar_pwm_driver_if.slave bus
);

    localparam int FADE_W = (FADE_PERIODS > 1) ? $clog2(FADE_PERIODS) : 1;
    localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'((FADE_PERIODS > 0) ? FADE_PERIODS - 1 : 0);

    logic               tick_unused;
    logic [FRAC_W-1:0]  pwm_cnt;
    logic               boundary;

    logic [LEVEL_W-1:0]  target_q;
    logic [LEVEL_W-1:0]  cur_level_q;
    logic [FADE_W-1:0]   fade_cnt_q;
    fade_state_e         state_q;
    logic [NUM_LEDS-1:0] led_out_q, led_out_d;
    logic                pwm_sync_q;

    logic               step_up, step_down, reversed;
    logic [LEVEL_W-1:0] next_level;

    led_pwm_timebase #(.CLK_DIV(CLK_DIV)) u_timebase (
        .clk       (clk),
        .reset     (reset),
        .tick_o    (tick_unused),
        .pwm_cnt_o (pwm_cnt),
        .boundary_o(boundary)
    );

    assign step_up    = (target_q > cur_level_q);
    assign step_down  = (target_q < cur_level_q);
    assign reversed   = ((state_q == RAMP_UP) && step_down) || ((state_q == RAMP_DOWN) && step_up);
    assign next_level = (state_q == RAMP_UP) ? cur_level_q + 1'b1 : cur_level_q - 1'b1;

    // Level only moves at a period boundary so the duty never changes mid-period.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fade_cnt_q  <= '0;
            cur_level_q <= '0;
        end else if (boundary) begin
            if (FADE_PERIODS == 0) begin
                cur_level_q <= target_q;
                state_q     <= IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        fade_cnt_q <= '0;
                        if (step_up)        state_q <= RAMP_UP;
                        else if (step_down) state_q <= RAMP_DOWN;
                    end
                    RAMP_UP, RAMP_DOWN: begin
                        if (!step_up && !step_down) begin
                            state_q <= IDLE;
                        end else if (reversed) begin
                            state_q    <= step_up ? RAMP_UP : RAMP_DOWN;
                            fade_cnt_q <= '0;
                        end else if (fade_cnt_q == FADE_LAST) begin
                            fade_cnt_q  <= '0;
                            cur_level_q <= next_level;
                            if (next_level == target_q) state_q <= IDLE;
                        end else begin
                            fade_cnt_q <= fade_cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        led_out_d = led_decode(cur_level_q, pwm_cnt);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q   <= '0;
            led_out_q  <= '0;
            pwm_sync_q <= 1'b0;
        end else begin
            target_q   <= bus.level_in;
            led_out_q  <= led_out_d;
            pwm_sync_q <= boundary;
        end
    end

    assign bus.led_out    = led_out_q;
    assign bus.pwm_sync   = pwm_sync_q;
    assign bus.busy       = (cur_level_q != target_q);
    assign bus.fade_state = state_q;
    assign bus.cur_level  = cur_level_q;

endmodule

// File: tb/tb_led_bar_pwm_driver.sv
// Directed bench: instance A (CLK_DIV=1, no fade) checks decode and duty; instance B checks fading.
module tb_led_bar_pwm_driver;
  import led_pwm_pkg::*;

  localparam int DIV_A = 1;
  localparam int DIV_B = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_checks = 0;
  int n_fails = 0;

  led_bar_pwm_driver_if if_a();
  led_bar_pwm_driver_if if_b();

  led_bar_pwm_driver #(.CLK_DIV(DIV_A), .FADE_PERIODS(0)) dut_a (
    .clk(clk), .reset(reset), .bus(if_a)
  );
  led_bar_pwm_driver #(.CLK_DIV(DIV_B), .FADE_PERIODS(2)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic sync_of(input int s);
    return (s == 0) ? if_a.pwm_sync : if_b.pwm_sync;
  endfunction

  // returns right after the sample in which pwm_sync is seen high
  task automatic wait_sync(input int s);
    int limit;
    logic seen;
    limit = 32 * ((s == 0) ? DIV_A : DIV_B) + 4;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge clk); #1;
      seen = sync_of(s);
    end
    check_eq($sformatf("sync_wait_%0d", s), 32'(seen), 32'd1);
  endtask

  // samples one full PWM period of instance A, optionally changing level_in mid-period
  task automatic measure(input string tag, input int exp_cnt[8],
                         input int p1 = -1, input logic [7:0] v1 = 8'h00,
                         input int p2 = -1, input logic [7:0] v2 = 8'h00);
    int cnt[8];
    foreach (cnt[k]) cnt[k] = 0;
    for (int j = 0; j < 32; j++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 8; k++) cnt[k] += int'(if_a.led_out[k]);
      if (j == p1) if_a.level_in = v1;
      if (j == p2) if_a.level_in = v2;
    end
    for (int k = 0; k < 8; k++) check_eq($sformatf("%s_led%0d", tag, k), 32'(cnt[k]), 32'(exp_cnt[k]));
    check_eq({tag, "_sync"}, 32'(if_a.pwm_sync), 32'd1);
  endtask

  initial begin
    int exp_cur[7];
    logic [7:0] max_cur;
    logic found;
    int n;
    exp_cur = '{0, 0, 1, 1, 2, 2, 3};
    if_a.level_in = 8'h00;
    if_b.level_in = 8'h00;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_led_a", 32'(if_a.led_out), 32'd0);
    check_eq("rst_sync_a", 32'(if_a.pwm_sync), 32'd0);
    check_eq("rst_busy_a", 32'(if_a.busy), 32'd0);
    check_eq("rst_led_b", 32'(if_b.led_out), 32'd0);
    check_eq("rst_state_b", 32'(if_b.fade_state), 32'(IDLE));
    reset = 1'b0;

    // level 0x4A: two LEDs solid, third at 10/32
    wait_sync(0);
    if_a.level_in = 8'h4A;
    wait_sync(0);
    measure("lvl4a", '{32, 32, 10, 0, 0, 0, 0, 0});

    // mid-period change is held until the boundary
    measure("mid_hold", '{32, 32, 10, 0, 0, 0, 0, 0}, 16, 8'h30);
    measure("mid_new", '{32, 16, 0, 0, 0, 0, 0, 0});
    measure("glitch", '{32, 16, 0, 0, 0, 0, 0, 0}, 10, 8'h80, 20, 8'h30);
    measure("glitch_after", '{32, 16, 0, 0, 0, 0, 0, 0}, 5, 8'hFF);

    // extremes
    measure("lvl_ff", '{32, 32, 32, 32, 32, 32, 32, 31}, 5, 8'h00);
    measure("lvl_00", '{0, 0, 0, 0, 0, 0, 0, 0});

    // fade 0 -> 3 with two periods per step
    wait_sync(1);
    if_b.level_in = 8'd3;
    check_eq("busy_before", 32'(if_b.busy), 32'd0);
    @(posedge clk); #1;
    check_eq("busy_rise", 32'(if_b.busy), 32'd1);
    for (int p = 0; p < 7; p++) begin
      wait_sync(1);
      check_eq($sformatf("fade_cur_p%0d", p), 32'(if_b.cur_level), 32'(exp_cur[p]));
      check_eq($sformatf("fade_state_p%0d", p), 32'(if_b.fade_state), (p < 6) ? 32'(RAMP_UP) : 32'(IDLE));
      check_eq($sformatf("fade_busy_p%0d", p), 32'(if_b.busy), (p < 6) ? 32'd1 : 32'd0);
    end

    // reversal at 40 toward 10
    if_b.level_in = 8'd100;
    found = 1'b0;
    for (int p = 0; p < 120 && !found; p++) begin
      wait_sync(1);
      found = (if_b.cur_level == 8'd40);
    end
    check_eq("rev_reach40", 32'(if_b.cur_level), 32'd40);
    if_b.level_in = 8'd10;
    wait_sync(1);
    check_eq("rev_state", 32'(if_b.fade_state), 32'(RAMP_DOWN));
    check_eq("rev_cur", 32'(if_b.cur_level), 32'd40);
    max_cur = if_b.cur_level;
    found = 1'b0;
    for (int p = 0; p < 100 && !found; p++) begin
      wait_sync(1);
      if (if_b.cur_level > max_cur) max_cur = if_b.cur_level;
      found = (if_b.cur_level == 8'd10);
    end
    check_eq("rev_no_overshoot", 32'(max_cur), 32'd40);
    check_eq("rev_final_cur", 32'(if_b.cur_level), 32'd10);
    check_eq("rev_final_state", 32'(if_b.fade_state), 32'(IDLE));
    check_eq("rev_final_busy", 32'(if_b.busy), 32'd0);

    // asynchronous reset mid-ramp
    if_b.level_in = 8'd200;
    repeat (5) wait_sync(1);
    check_eq("pre_rst_busy", 32'(if_b.busy), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_led_a", 32'(if_a.led_out), 32'd0);
    check_eq("arst_led_b", 32'(if_b.led_out), 32'd0);
    check_eq("arst_busy_b", 32'(if_b.busy), 32'd0);
    check_eq("arst_sync_b", 32'(if_b.pwm_sync), 32'd0);
    check_eq("arst_cur_b", 32'(if_b.cur_level), 32'd0);
    check_eq("arst_state_b", 32'(if_b.fade_state), 32'(IDLE));
    if_b.level_in = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    found = 1'b0;
    while (n < 200 && !found) begin
      @(posedge clk); #1;
      n++;
      found = if_b.pwm_sync;
    end
    check_eq("first_sync_cycles", 32'(n), 32'(32 * DIV_B));
    @(posedge clk); #1;
    check_eq("sync_one_cycle", 32'(if_b.pwm_sync), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
